pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_cmp.sv | 31 +++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared state encoding, register constants and latency defaults
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LDBR   = 2'd1,
    ST_MDBUSY = 2'd2,
    ST_BAD    = 2'd3
  } pipe_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MUL_CYCLES_DEF = 4;
  localparam int         DIV_CYCLES_DEF = 32;

  // Countdown start value: the unit finishes when the counter reaches zero.
  function automatic logic [5:0] md_load(input logic op, input int mul_cyc, input int div_cyc);
    return op ? 6'(div_cyc - 1) : 6'(mul_cyc - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// pipe_ctrl_if : hazard inputs and stall/flush controls of the pipeline
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface pipe_ctrl_if;

  logic       MemR_EX;
  logic [4:0] EX_rfWeSel;
  logic       EX_rfWe;
  logic [4:0] rfReSel1;
  logic [4:0] rfReSel2;
  logic       Branch;
  logic       br_taken;
  logic       md_req;
  logic       md_op;

  logic       pc_we;
  logic       ifid_we;
  logic       ifid_flush;
  logic       Nop;
  logic       md_start;
  logic       md_busy;
  logic       md_done;
  logic [1:0] state;

  modport master (
    output MemR_EX, EX_rfWeSel, EX_rfWe, rfReSel1, rfReSel2,
           Branch, br_taken, md_req, md_op,
    input  pc_we, ifid_we, ifid_flush, Nop, md_start, md_busy, md_done, state
  );

  modport slave (
    input  MemR_EX, EX_rfWeSel, EX_rfWe, rfReSel1, rfReSel2,
           Branch, br_taken, md_req, md_op,
    output pc_we, ifid_we, ifid_flush, Nop, md_start, md_busy, md_done, state
  );

endinterface

`default_nettype wire

// File: rtl/pipe_hazard_cmp.sv
// ============================================================================
// pipe_hazard_cmp : EX-destination vs ID-source match, load-use / branch-ALU
// Revision        : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_cmp
  import pipe_pkg::*;
(
  input  logic       mem_r_ex_i,
  input  logic       ex_we_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       branch_i,
  output logic       load_use_o,
  output logic       branch_alu_o
);

  logic rd_valid;
  logic match;

  assign rd_valid     = (ex_rd_i != REG_ZERO);
  assign match        = rd_valid && ((ex_rd_i == rs1_i) || (ex_rd_i == rs2_i));
  assign load_use_o   = mem_r_ex_i && match;
  // Branches resolve in ID, so an ALU result still in EX must be waited for.
  assign branch_alu_o = branch_i && ex_we_i && !mem_r_ex_i && match;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : pipeline stall/flush controller with mult/div busy sequencing
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  pipe_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        load_use;
  logic        branch_alu;
  logic        hazard;

  logic pc_we, ifid_we, ifid_flush, nop, md_start, md_busy, md_done;

  pipe_hazard_cmp u_cmp (
    .mem_r_ex_i   (bus.MemR_EX),
    .ex_we_i      (bus.EX_rfWe),
    .ex_rd_i      (bus.EX_rfWeSel),
    .rs1_i        (bus.rfReSel1),
    .rs2_i        (bus.rfReSel2),
    .branch_i     (bus.Branch),
    .load_use_o   (load_use),
    .branch_alu_o (branch_alu)
  );

  assign hazard = load_use || branch_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (load_use) begin
          state_d = bus.Branch ? ST_LDBR : ST_RUN;
        end else if (branch_alu) begin
          state_d = ST_RUN;
        end else if (bus.Branch && bus.br_taken) begin
          state_d = ST_RUN;
        end else if (bus.md_req) begin
          state_d = ST_MDBUSY;
          cnt_d   = md_load(bus.md_op, MUL_CYCLES, DIV_CYCLES);
        end
      end
      ST_LDBR:   state_d = ST_RUN;
      ST_MDBUSY: begin
        if (cnt_q == 6'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 6'd1;
      end
      default:   state_d = ST_RUN;
    endcase
  end

  // Stall values are the default so reset and the unused encoding share them.
  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    nop        = 1'b1;
    md_start   = 1'b0;
    md_busy    = 1'b0;
    md_done    = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            nop = 1'b1;
          end else if (bus.Branch && bus.br_taken) begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            nop        = 1'b0;
          end else if (bus.md_req) begin
            md_start = 1'b1;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            nop     = 1'b0;
          end
        end
        ST_MDBUSY: begin
          if (cnt_q == 6'd0) begin
            md_done = 1'b1;
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            nop     = 1'b0;
          end else begin
            md_busy = 1'b1;
          end
        end
        default: nop = 1'b1;
      endcase
    end
  end

  assign bus.pc_we      = pc_we;
  assign bus.ifid_we    = ifid_we;
  assign bus.ifid_flush = ifid_flush;
  assign bus.Nop        = nop;
  assign bus.md_start   = md_start;
  assign bus.md_busy    = md_busy;
  assign bus.md_done    = md_done;
  assign bus.state      = state_q;

endmodule

`default_nettype wire
